// File: rtl/glip_pattern_checker_pkg.sv
// Shared constants and types for the GLIP pattern checker slice.
// Holds the forwarding buffer depth and the per-word check outcome.
package glip_pattern_checker_pkg;

    localparam int BUF_DEPTH = 2;

    // Outcome of one accepted word, consumed by the counter logic.
    typedef enum logic [1:0] {
        EV_IDLE,
        EV_LOCK,
        EV_MATCH,
        EV_MISMATCH
    } chk_event_e;

endpackage

// File: rtl/glip_pattern_checker_if.sv
// Valid/ready word stream between the checker top and its forwarding buffer.
interface glip_pattern_checker_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/glip_pattern_checker_buf.sv
// Two-entry FIFO that forwards words unmodified and in order.
// It stays not-ready during reset and becomes ready on the first clock after release.
module glip_pattern_checker_buf
    import glip_pattern_checker_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    glip_pattern_checker_if.slave  s_in,
    glip_pattern_checker_if.master m_out
);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_up;

    logic w_push;
    logic w_pop;

    assign s_in.ready  = r_up && (r_count != 2'(BUF_DEPTH));
    assign m_out.valid = (r_count != 2'd0);
    assign m_out.data  = r_mem[r_rd_ptr];

    assign w_push = s_in.valid && s_in.ready;
    assign w_pop  = m_out.valid && m_out.ready;

    // NOTE: the storage is reset too, so out_data reads 0 while the buffer is empty after reset.
    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_up     <= 1'b0;
        end else begin
            r_up <= 1'b1;
            if (w_push) begin
                r_mem[r_wr_ptr] <= s_in.data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/glip_pattern_checker.sv
// Incrementing-pattern checker: forwards GLIP words through a 2-entry buffer while
// tracking lock, word and error counts against an expected +1 sequence.
module glip_pattern_checker
    import glip_pattern_checker_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 locked,
    output logic                 err_seen
);

    localparam logic ST_HUNT_ENC  = 1'b0;
    localparam logic ST_TRACK_ENC = 1'b1;
    localparam int   MIS_W        = $clog2(LOSS_THRESH + 1);

    typedef enum logic {
        HUNT  = ST_HUNT_ENC,
        TRACK = ST_TRACK_ENC
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] w_expected_nxt;
    logic [MIS_W-1:0] r_mis;
    logic [MIS_W-1:0] w_mis_nxt;
    chk_event_e       w_event;
    logic             w_accept;

    logic [CNT_WIDTH-1:0] r_word_count;
    logic [CNT_WIDTH-1:0] r_err_count;
    logic                 r_err_seen;

    glip_pattern_checker_if #(.WIDTH(WIDTH)) w_in_if ();
    glip_pattern_checker_if #(.WIDTH(WIDTH)) w_out_if ();

    assign w_in_if.data   = in_data;
    assign w_in_if.valid  = in_valid;
    assign in_ready       = w_in_if.ready;
    assign out_data       = w_out_if.data;
    assign out_valid      = w_out_if.valid;
    assign w_out_if.ready = out_ready;

    glip_pattern_checker_buf #(.WIDTH(WIDTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .s_in  (w_in_if.slave),
        .m_out (w_out_if.master)
    );

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_expected <= '0;
            r_mis      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_expected <= w_expected_nxt;
            r_mis      <= w_mis_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_mis_nxt      = r_mis;
        w_event        = EV_IDLE;
        if (clear) begin
            w_state_nxt = HUNT;
            w_mis_nxt   = '0;
        end else if (w_accept) begin
            // Both a match and a resync leave expected one past the word just seen.
            w_expected_nxt = in_data + WIDTH'(1);
            case (r_state)
                HUNT: begin
                    w_event     = EV_LOCK;
                    w_state_nxt = TRACK;
                    w_mis_nxt   = '0;
                end
                TRACK: begin
                    if (in_data == r_expected) begin
                        w_event   = EV_MATCH;
                        w_mis_nxt = '0;
                    end else begin
                        w_event = EV_MISMATCH;
                        if (r_mis == MIS_W'(LOSS_THRESH - 1)) begin
                            w_state_nxt = HUNT;
                            w_mis_nxt   = '0;
                        end else begin
                            w_mis_nxt = r_mis + MIS_W'(1);
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Counters saturate at all-ones; clear outranks a coincident accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
            r_err_count  <= '0;
            r_err_seen   <= 1'b0;
        end else if (clear) begin
            r_word_count <= '0;
            r_err_count  <= '0;
            r_err_seen   <= 1'b0;
        end else if (w_event != EV_IDLE) begin
            if (!(&r_word_count)) begin
                r_word_count <= r_word_count + CNT_WIDTH'(1);
            end
            if (w_event == EV_MISMATCH) begin
                r_err_seen <= 1'b1;
                if (!(&r_err_count)) begin
                    r_err_count <= r_err_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign word_count = r_word_count;
    assign err_count  = r_err_count;
    assign err_seen   = r_err_seen;
    assign locked     = (r_state == TRACK);

endmodule

// File: doc/glip_pattern_checker.md
GLIP_PATTERN_CHECKER -- requirements
Module: glip_pattern_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width (16 or 32).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of the word and error counters.
REQ-003 SHALL have parameter LOSS_THRESH, default 4, number of consecutive mismatches that drops lock.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear  input  1  synchronous pulse; zeroes counters and returns to HUNT.
REQ-007 SHALL have port in_data  input  WIDTH  word from the GLIP host->logic FIFO.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  checker can accept a word.
REQ-010 SHALL have port out_data  output  WIDTH  forwarded word to the GLIP logic->host FIFO.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port word_count  output  CNT_WIDTH  accepted words since reset/clear.
REQ-014 SHALL have port err_count  output  CNT_WIDTH  mismatching words since reset/clear.
REQ-015 SHALL have port locked  output  1  checker in TRACK state.
REQ-016 SHALL have port err_seen  output  1  sticky, at least one mismatch since reset/clear.

Function
REQ-017 SHALL accept a word on any cycle where in_valid && in_ready (accept event).
REQ-018 SHALL forward every accepted word unmodified and in order through a 2-entry FIFO buffer; in_ready = buffer not full, out_valid = buffer not empty.
REQ-019 SHALL present an accepted word on out_data/out_valid no earlier than the cycle after acceptance (latency 1 with an empty buffer and out_ready high).
REQ-020 SHALL sustain one word per cycle when out_ready is held high; simultaneous push and pop on a full buffer SHALL NOT occur because in_ready is low while full.
REQ-021 SHALL hold out_data stable while out_valid && !out_ready.
REQ-022 SHALL implement states HUNT and TRACK; reset and clear enter HUNT.
REQ-023 In HUNT, an accept event SHALL load expected = in_data + 1 (mod 2^WIDTH), go to TRACK, and count the word without error.
REQ-024 In TRACK, an accept event with in_data == expected SHALL set expected = expected + 1 and zero the consecutive-mismatch counter.
REQ-025 In TRACK, an accept event with in_data != expected SHALL increment err_count, set err_seen, set expected = in_data + 1 (resync), and increment the consecutive-mismatch counter.
REQ-026 When the consecutive-mismatch counter reaches LOSS_THRESH, the FSM SHALL go to HUNT and clear that counter.
REQ-027 expected SHALL wrap from 2^WIDTH-1 to 0 without an error.
REQ-028 word_count SHALL increment by 1 per accept event; word_count and err_count SHALL saturate at all-ones.
REQ-029 clear coincident with an accept event SHALL win: counters become 0, err_seen 0, state HUNT, and the word is still forwarded but not counted.
REQ-030 clear SHALL NOT flush the forwarding buffer.

Reset
REQ-031 On rst_n low, SHALL asynchronously force: buffer empty, out_valid 0, in_ready 0 during reset, out_data 0, word_count 0, err_count 0, err_seen 0, locked 0, expected 0, state HUNT.
REQ-032 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge.

Structure
REQ-033 SHALL define the HUNT/TRACK state encoding as a localparam inside this module; no shared package is needed.
REQ-034 SHALL instantiate the 2-entry buffer as sub-module glip_pattern_checker_buf (parameter WIDTH).

Verification
REQ-035 Bench SHALL send 0x0005..0x0104 (256 words), out_ready=1 -> identical output stream, word_count=256, err_count=0, locked=1 after the first word.
REQ-036 Bench SHALL send 0xFFFE,0xFFFF,0x0000,0x0001 with WIDTH=16 -> err_count=0 (wrap).
REQ-037 Bench SHALL send 1,2,3,9,10 -> err_count=1, err_seen=1, locked stays 1, all five words forwarded.
REQ-038 Bench SHALL send 1,5,9,13,17 (LOSS_THRESH=4) -> err_count=4 and locked=0 after the fifth word; the next word relocks.
REQ-039 Bench SHALL hold out_ready=0 during a 3-word burst -> in_ready=0 after 2 accepts, out_data stable, no loss once out_ready=1.
REQ-040 Bench SHALL pulse clear on the same cycle as an accept after 10 words -> word_count=0, err_count=0, state HUNT, word still forwarded.
